// File: rtl/booth_seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential signed divider.
// Latency: none (wires only).
// Backpressure: the master may raise start only while busy=0; start seen during busy is dropped.
interface booth_seq_divider_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/booth_seq_divider.sv
// Signed restoring divider, one quotient bit per clock, truncating toward zero.
// Latency: start accepted at edge k -> done high after edge k+DATA_WIDTH+1, for every operand.
// Backpressure: busy in CALC/FIX, start ignored then; start in DONE runs back-to-back.
module booth_seq_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_divider_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  dq_q;
    logic [W-1:0]  dvs_mag_q;
    logic [W-1:0]  dvd_q;
    logic          dvd_neg_q;
    logic          quo_neg_q;
    logic          dvs_zero_q;
    logic          ovf_pend_q;

    logic [W-1:0]  quotient_q;
    logic [W-1:0]  remainder_q;
    logic          div_by_zero_q;
    logic          overflow_q;

    logic          accept;
    logic          last_iter;
    logic [W-1:0]  dvd_abs;
    logic [W-1:0]  dvs_abs;
    logic [W:0]    rem_shift;
    logic [W:0]    rem_sub;
    logic          rem_ge;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    // MIN negates to itself, which read as unsigned is exactly 2^(W-1).
    always_comb begin
        accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_iter = (cnt_q == CW'(W-1));
        dvd_abs   = bus.dividend[W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_abs   = bus.divisor[W-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    end

    // rem_q < |divisor| <= 2^(W-1), so the shifted value fits W bits and rem_sub[W] is the borrow.
    always_comb begin
        rem_shift = {rem_q, dq_q[W-1]};
        rem_sub   = rem_shift - {1'b0, dvs_mag_q};
        rem_ge    = ~rem_sub[W];
    end

    always_comb begin
        q_fix = quo_neg_q ? (~dq_q + 1'b1) : dq_q;
        r_fix = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (dvs_zero_q) begin
            q_fix = '1;
            r_fix = dvd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CALC;
            end
            S_CALC: begin
                bus.busy = 1'b1;
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                bus.busy = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = accept ? S_CALC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            dvs_mag_q  <= '0;
            dvd_q      <= '0;
            dvd_neg_q  <= 1'b0;
            quo_neg_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            dq_q       <= dvd_abs;
            dvs_mag_q  <= dvs_abs;
            dvd_q      <= bus.dividend;
            dvd_neg_q  <= bus.dividend[W-1];
            quo_neg_q  <= bus.dividend[W-1] ^ bus.divisor[W-1];
            dvs_zero_q <= (bus.divisor == '0);
            ovf_pend_q <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
            dq_q  <= {dq_q[W-2:0], rem_ge};
        end
    end

    // Results only move on the FIX->DONE edge and hold through any later start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (state_q == S_FIX) begin
            quotient_q    <= q_fix;
            remainder_q   <= r_fix;
            div_by_zero_q <= dvs_zero_q;
            overflow_q    <= ovf_pend_q && !dvs_zero_q;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed and random checks of booth_seq_divider (W=8) against a truncating-division model.
module tb_booth_seq_divider;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    booth_seq_divider_if #(.DATA_WIDTH(W)) bif ();

    booth_seq_divider #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division in SV truncates toward zero, % follows the dividend.
    task automatic model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int ai, bi, qi, ri;
        ai = a;
        bi = b;
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (ai == -(2 ** (W-1)) && bi == -1) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[W-1:0];
            r  = ri[W-1:0];
        end
    endtask

    task automatic check_result(input string tag, input logic signed [W-1:0] a,
                                input logic signed [W-1:0] b);
        logic [W-1:0] q, r;
        logic         dz, ov;
        model(a, b, q, r, dz, ov);
        check({tag, "_q"},   32'(bif.quotient),    32'(q));
        check({tag, "_r"},   32'(bif.remainder),   32'(r));
        check({tag, "_dz"},  32'(bif.div_by_zero), 32'(dz));
        check({tag, "_ov"},  32'(bif.overflow),    32'(ov));
    endtask

    // Present operands, let one edge accept them, then scramble the inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bif.start    = 1'b1;
        bif.dividend = a;
        bif.divisor  = b;
        @(posedge clk);
        #1;
        bif.start    = 1'b0;
        bif.dividend = W'($urandom);
        bif.divisor  = W'($urandom);
    endtask

    // Called #1 after the accepting edge; counts edges until done, optionally injecting a stray start.
    task automatic wait_done(input int pulse_at, input logic [W-1:0] pa, input logic [W-1:0] pb,
                             output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = (bif.busy === 1'b1) ? 1 : 0;
        while (bif.done !== 1'b1 && edges < 40) begin
            if (edges == pulse_at) begin
                bif.start    = 1'b1;
                bif.dividend = pa;
                bif.divisor  = pb;
            end else begin
                bif.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (bif.busy === 1'b1) busy_cnt++;
        end
        bif.start = 1'b0;
        if (edges >= 40) check("done_timeout", 32'(edges), 32'(W+1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int edges, busy_cnt;
        issue(a, b);
        wait_done(-1, '0, '0, edges, busy_cnt);
        check({tag, "_lat"}, 32'(edges), 32'(W+1));
        check_result(tag, a, b);
    endtask

    initial begin
        int edges, busy_cnt, done_seen;
        logic [W-1:0] ra, rb;

        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bif.start    = 1'b0;
        bif.dividend = '0;
        bif.divisor  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bif.busy),        32'd0);
        check("rst_done", 32'(bif.done),        32'd0);
        check("rst_q",    32'(bif.quotient),    32'd0);
        check("rst_r",    32'(bif.remainder),   32'd0);
        check("rst_dz",   32'(bif.div_by_zero), 32'd0);
        check("rst_ov",   32'(bif.overflow),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic op: latency, busy width, single-cycle done.
        issue(8'd7, 8'd2);
        wait_done(-1, '0, '0, edges, busy_cnt);
        check("basic_lat",  32'(edges),    32'(W+1));
        check("basic_busy", 32'(busy_cnt), 32'(W+1));
        check_result("basic", 8'd7, 8'd2);
        @(posedge clk);
        #1;
        check("basic_done_pulse", 32'(bif.done), 32'd0);
        check("basic_hold_q",     32'(bif.quotient), 32'd3);

        run_op("sgn_nd",  -8'sd7,  8'sd2);
        run_op("sgn_dn",   8'sd7, -8'sd2);
        run_op("sgn_nn",  -8'sd7, -8'sd2);
        run_op("min_m1",  8'h80,  8'hFF);
        run_op("min_p1",  8'h80,  8'h01);
        run_op("min_min", 8'h80,  8'h80);
        run_op("max_min", 8'h7F,  8'h80);
        run_op("small",   8'd3,   8'd100);

        // Stray start during CALC must not disturb the op in flight.
        issue(8'd100, 8'd7);
        wait_done(2, 8'd55, 8'd3, edges, busy_cnt);
        check("ign_lat", 32'(edges), 32'(W+1));
        check_result("ign", 8'd100, 8'd7);
        @(posedge clk);
        #1;
        check("ign_no_rerun", 32'(bif.busy), 32'd0);

        // Back-to-back: start held into DONE launches the next op at once.
        issue(-8'sd50, 8'sd6);
        wait_done(-1, '0, '0, edges, busy_cnt);
        check("b2b1_lat", 32'(edges), 32'(W+1));
        check_result("b2b1", -8'sd50, 8'sd6);
        bif.start    = 1'b1;
        bif.dividend = 8'd77;
        bif.divisor  = -8'sd9;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check("b2b_done_pulse", 32'(bif.done), 32'd0);
        check("b2b_busy",       32'(bif.busy), 32'd1);
        wait_done(-1, '0, '0, edges, busy_cnt);
        check("b2b2_lat", 32'(edges), 32'(W+1));
        check_result("b2b2", 8'd77, -8'sd9);

        run_op("dbz", 8'd5, 8'd0);

        // Reset in the middle of CALC.
        issue(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bif.busy),        32'd0);
        check("mrst_done", 32'(bif.done),        32'd0);
        check("mrst_q",    32'(bif.quotient),    32'd0);
        check("mrst_r",    32'(bif.remainder),   32'd0);
        check("mrst_dz",   32'(bif.div_by_zero), 32'd0);
        done_seen = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1) done_seen++;
        end
        check("mrst_no_done", 32'(done_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", -8'sd100, 8'sd7);

        for (int i = 0; i < 3000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (rb == '0) rb = 8'h01;
            if (ra == 8'h80 && rb == 8'hFF) rb = 8'h01;
            run_op("rnd", ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
